ibex_mem_responder: RTL and testbench

IBEX_MEM_RESPONDER -- requirements
Module: ibex_mem_responder

---
 rtl/ibex_mem_responder_if.sv | 34 +++
 rtl/ibex_mem_responder.sv | 130 +++++++++++++
 tb/tb_ibex_mem_responder.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_mem_responder_if.sv
// Core-side instruction and data request/response bus seen by the memory responder.
// The core (master) drives requests; the responder (slave) drives grants and responses.
interface ibex_mem_responder_if;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;

    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;

    modport master (
        output instr_req_i, instr_addr_i,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );

    modport slave (
        input  instr_req_i, instr_addr_i,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );
endinterface

// File: rtl/ibex_mem_responder.sv
// Arbitrates Ibex instruction/data ports onto one RAM port, flags out-of-range accesses as errors.
// Latency: grant combinational in the request cycle, response exactly one cycle after grant.
// Backpressure: none; one grant per cycle, the losing port keeps requesting until granted.
module ibex_mem_responder #(
    parameter int unsigned DEPTH     = 16384,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    ibex_mem_responder_if.slave  bus,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [3:0]           mem_be_o,
    output logic [31:0]          mem_addr_o,
    output logic [31:0]          mem_wdata_o,
    input  logic                 mem_rvalid_i,
    input  logic [31:0]          mem_rdata_i,
    output logic [15:0]          err_count_o
);

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } port_e;

    // 34 bits so a RAM covering the whole 4 GiB space cannot wrap the limit
    localparam logic [33:0] SPAN = 34'(DEPTH) << 2;

    function automatic logic in_range(input logic [31:0] addr);
        logic [33:0] off;
        off = {2'b00, addr} - {2'b00, BASE_ADDR};
        return (addr >= BASE_ADDR) && (off < SPAN);
    endfunction

    port_e       last_q, last_d;
    logic        slot_vld_q, slot_vld_d;
    port_e       slot_port_q, slot_port_d;
    logic        slot_err_q, slot_err_d;
    logic [15:0] err_count_q, err_count_d;

    logic        contested;
    logic        gnt_instr, gnt_data, gnt_any;
    logic [31:0] sel_addr;
    logic        sel_in_range;
    logic        rsp_ok, rsp_err;

    always_comb begin
        contested = reset && bus.instr_req_i && bus.data_req_i;
        // on contention the port that lost the previous contest wins
        gnt_data  = reset && bus.data_req_i && (!bus.instr_req_i || last_q == PORT_INSTR);
        gnt_instr = reset && bus.instr_req_i && !gnt_data;
        gnt_any   = gnt_instr || gnt_data;

        sel_addr     = gnt_data ? bus.data_addr_i : bus.instr_addr_i;
        sel_in_range = in_range(sel_addr);

        mem_req_o   = gnt_any && sel_in_range;
        mem_addr_o  = 32'h0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_wdata_o = 32'h0;
        if (mem_req_o) begin
            mem_addr_o = sel_addr - BASE_ADDR;
            if (gnt_data) begin
                mem_we_o    = bus.data_we_i;
                mem_be_o    = bus.data_be_i;
                mem_wdata_o = bus.data_wdata_i;
            end else begin
                mem_be_o    = 4'hF;
            end
        end

        bus.instr_gnt_o = gnt_instr;
        bus.data_gnt_o  = gnt_data;
    end

    always_comb begin
        rsp_ok  = reset && slot_vld_q && !slot_err_q && mem_rvalid_i;
        rsp_err = reset && slot_vld_q && slot_err_q;

        bus.instr_rvalid_o = 1'b0;
        bus.instr_err_o    = 1'b0;
        bus.instr_rdata_o  = 32'h0;
        bus.data_rvalid_o  = 1'b0;
        bus.data_err_o     = 1'b0;
        bus.data_rdata_o   = 32'h0;
        if (slot_port_q == PORT_DATA) begin
            bus.data_rvalid_o = rsp_ok || rsp_err;
            bus.data_err_o    = rsp_err;
            bus.data_rdata_o  = rsp_ok ? mem_rdata_i : 32'h0;
        end else begin
            bus.instr_rvalid_o = rsp_ok || rsp_err;
            bus.instr_err_o    = rsp_err;
            bus.instr_rdata_o  = rsp_ok ? mem_rdata_i : 32'h0;
        end
    end

    always_comb begin
        last_d      = last_q;
        slot_vld_d  = gnt_any;
        slot_port_d = gnt_data ? PORT_DATA : PORT_INSTR;
        slot_err_d  = gnt_any && !sel_in_range;
        err_count_d = err_count_q;
        if (contested) begin
            last_d = gnt_data ? PORT_DATA : PORT_INSTR;
        end
        if (rsp_err && err_count_q != 16'hFFFF) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_q      <= PORT_INSTR;
            slot_vld_q  <= 1'b0;
            slot_port_q <= PORT_INSTR;
            slot_err_q  <= 1'b0;
            err_count_q <= 16'h0;
        end else begin
            last_q      <= last_d;
            slot_vld_q  <= slot_vld_d;
            slot_port_q <= slot_port_d;
            slot_err_q  <= slot_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign err_count_o = err_count_q;

endmodule

// File: tb/tb_ibex_mem_responder.sv
// Directed bench for ibex_mem_responder with a transaction-level reference model and a 1-cycle RAM.
module tb_ibex_mem_responder;
    localparam int          DEPTH = 16384;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ibex_mem_responder_if bus();

    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic [15:0] err_count_o;
    logic        inject;

    int passed = 0;
    int total  = 0;

    ibex_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .err_count_o  (err_count_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // RAM: answers every access one cycle later; writes answer with zero data
    logic [31:0] ram [DEPTH];
    logic [31:0] ram_w;
    always @(posedge clk) begin
        mem_rvalid_i <= inject;
        mem_rdata_i  <= 32'hBAD0_0000;
        if (!reset) begin
            ram[14'h0020] <= 32'h0000_0013;
            ram[14'h0040] <= 32'h1234_5678;
            ram[14'h3FFF] <= 32'hCAFE_F00D;
        end
        if (mem_req_o) begin
            mem_rvalid_i <= 1'b1;
            if (mem_we_o) begin
                ram_w = ram[mem_addr_o[15:2]];
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) ram_w[8*b +: 8] = mem_wdata_o[8*b +: 8];
                ram[mem_addr_o[15:2]] <= ram_w;
                mem_rdata_i <= 32'h0;
            end else begin
                mem_rdata_i <= ram[mem_addr_o[15:2]];
            end
        end
    end

    // Reference model: arbitration history, one pending response, its own memory image
    logic [31:0] mdl_mem [DEPTH];
    bit          m_last_data;
    bit          p_vld, p_data, p_err;
    logic [31:0] p_rdata;
    int          m_errs;
    bit          e_ig, e_dg, e_mreq, e_rsp, inr;
    logic [31:0] a, mw;
    longint      la;
    int          widx;

    always @(negedge clk) begin
        e_ig = 1'b0;
        e_dg = 1'b0;
        if (reset) begin
            e_dg = bus.data_req_i && (!bus.instr_req_i || !m_last_data);
            e_ig = bus.instr_req_i && !e_dg;
        end
        a      = e_dg ? bus.data_addr_i : bus.instr_addr_i;
        la     = {32'h0, a};
        inr    = (la >= longint'({32'h0, BASE})) && (la < longint'({32'h0, BASE}) + 4 * longint'(DEPTH));
        e_mreq = (e_ig || e_dg) && inr;
        e_rsp  = reset && p_vld;

        check("instr_gnt", bus.instr_gnt_o, e_ig);
        check("data_gnt", bus.data_gnt_o, e_dg);
        check("mem_req", mem_req_o, e_mreq);
        if (e_mreq || !reset) begin
            check("mem_addr", mem_addr_o, e_mreq ? a - BASE : 32'h0);
            check("mem_we", mem_we_o, e_mreq && e_dg && bus.data_we_i);
            check("mem_be", mem_be_o, !e_mreq ? 4'h0 : (e_dg ? bus.data_be_i : 4'hF));
            check("mem_wdata", mem_wdata_o, (e_mreq && e_dg) ? bus.data_wdata_i : 32'h0);
        end
        check("instr_rvalid", bus.instr_rvalid_o, e_rsp && !p_data);
        check("instr_err", bus.instr_err_o, e_rsp && !p_data && p_err);
        check("instr_rdata", bus.instr_rdata_o, (e_rsp && !p_data) ? p_rdata : 32'h0);
        check("data_rvalid", bus.data_rvalid_o, e_rsp && p_data);
        check("data_err", bus.data_err_o, e_rsp && p_data && p_err);
        check("data_rdata", bus.data_rdata_o, (e_rsp && p_data) ? p_rdata : 32'h0);
        check("err_count", err_count_o, m_errs);

        if (!reset) begin
            m_last_data = 1'b0;
            p_vld       = 1'b0;
            m_errs      = 0;
            mdl_mem[14'h0020] = 32'h0000_0013;
            mdl_mem[14'h0040] = 32'h1234_5678;
            mdl_mem[14'h3FFF] = 32'hCAFE_F00D;
        end else begin
            if (e_rsp && p_err && m_errs < 65535) m_errs++;
            if (bus.instr_req_i && bus.data_req_i) m_last_data = e_dg;
            p_vld   = e_ig || e_dg;
            p_data  = e_dg;
            p_err   = !inr;
            p_rdata = 32'h0;
            if (e_mreq) begin
                widx = int'((a - BASE) >> 2);
                if (e_dg && bus.data_we_i) begin
                    mw = mdl_mem[widx];
                    for (int b = 0; b < 4; b++)
                        if (bus.data_be_i[b]) mw[8*b +: 8] = bus.data_wdata_i[8*b +: 8];
                    mdl_mem[widx] = mw;
                end else begin
                    p_rdata = mdl_mem[widx];
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.instr_req_i  = 1'b0;
        bus.instr_addr_i = 32'h0;
        bus.data_req_i   = 1'b0;
        bus.data_we_i    = 1'b0;
        bus.data_be_i    = 4'hF;
        bus.data_addr_i  = 32'h0;
        bus.data_wdata_i = 32'h0;
    endtask

    logic [31:0] rd;

    initial begin
        reset  = 1'b0;
        inject = 1'b1;
        idle();
        // reset with both ports requesting and spurious RAM responses
        bus.instr_req_i = 1'b1;
        bus.data_req_i  = 1'b1;
        repeat (3) cyc();
        @(negedge clk);
        check("rst_data_gnt", bus.data_gnt_o, 1'b0);
        check("rst_err_count", err_count_o, 16'h0);
        cyc();

        // instruction fetch of 0x80 in the first cycle out of reset
        reset = 1'b1;
        inject = 1'b0;
        idle();
        bus.instr_req_i  = 1'b1;
        bus.instr_addr_i = 32'h80;
        @(negedge clk);
        check("fetch_gnt", bus.instr_gnt_o, 1'b1);
        check("fetch_mem_addr", mem_addr_o, 32'h80);
        cyc();
        idle();
        @(negedge clk);
        check("fetch_rvalid", bus.instr_rvalid_o, 1'b1);
        check("fetch_rdata", bus.instr_rdata_o, 32'h0000_0013);
        check("fetch_err", bus.instr_err_o, 1'b0);
        cyc();

        // partial write then back-to-back readback
        bus.data_req_i   = 1'b1;
        bus.data_we_i    = 1'b1;
        bus.data_be_i    = 4'b0011;
        bus.data_addr_i  = 32'h100;
        bus.data_wdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        check("wr_mem_be", mem_be_o, 4'b0011);
        check("wr_mem_we", mem_we_o, 1'b1);
        cyc();
        bus.data_we_i    = 1'b0;
        bus.data_be_i    = 4'hF;
        bus.data_wdata_i = 32'h0;
        @(negedge clk);
        check("wr_ack", bus.data_rvalid_o, 1'b1);
        cyc();
        idle();
        @(negedge clk);
        rd = bus.data_rdata_o;
        check("rb_low", rd[15:0], 16'hBEEF);
        check("rb_word", rd, 32'h1234_BEEF);
        cyc();

        // four contested cycles alternate starting with data
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                bus.instr_req_i  = 1'b1;
                bus.instr_addr_i = 32'h80;
                bus.data_req_i   = 1'b1;
                bus.data_we_i    = 1'b1;
                bus.data_addr_i  = 32'h200 + 32'(4 * k);
                bus.data_wdata_i = 32'(k);
            end else begin
                idle();
            end
            @(negedge clk);
            if (k < 4) check("rr_data_gnt", bus.data_gnt_o, (k % 2) == 0);
            if (k > 0) begin
                check("rr_data_rvalid", bus.data_rvalid_o, k == 1 || k == 3);
                check("rr_instr_rvalid", bus.instr_rvalid_o, k == 2 || k == 4);
            end
            cyc();
        end

        // data read just past the top of RAM, with a stray RAM rvalid alongside
        bus.data_req_i  = 1'b1;
        bus.data_addr_i = 32'h0001_0000;
        inject = 1'b1;
        @(negedge clk);
        check("oor_gnt", bus.data_gnt_o, 1'b1);
        check("oor_mem_req", mem_req_o, 1'b0);
        cyc();
        idle();
        inject = 1'b0;
        @(negedge clk);
        check("oor_rvalid", bus.data_rvalid_o, 1'b1);
        check("oor_err", bus.data_err_o, 1'b1);
        check("oor_rdata", bus.data_rdata_o, 32'h0);
        cyc();
        @(negedge clk);
        check("oor_count", err_count_o, 16'd1);
        cyc();

        // last RAM word, then top of address space
        bus.instr_req_i  = 1'b1;
        bus.instr_addr_i = 32'h0000_FFFC;
        @(negedge clk);
        check("top_mem_req", mem_req_o, 1'b1);
        cyc();
        bus.instr_addr_i = 32'hFFFF_FFFC;
        @(negedge clk);
        check("top_mem_req_oor", mem_req_o, 1'b0);
        check("top_rdata", bus.instr_rdata_o, 32'hCAFE_F00D);
        cyc();
        idle();
        @(negedge clk);
        check("top_err", bus.instr_err_o, 1'b1);
        cyc();

        // grant immediately followed by reset leaves nothing behind
        bus.instr_req_i  = 1'b1;
        bus.instr_addr_i = 32'h80;
        bus.data_req_i   = 1'b1;
        bus.data_addr_i  = 32'h0002_0000;
        @(negedge clk);
        check("pre_rst_data_gnt", bus.data_gnt_o, 1'b1);
        cyc();
        reset = 1'b0;
        idle();
        @(negedge clk);
        check("rst_n1_rvalid", bus.data_rvalid_o, 1'b0);
        check("rst_n1_err", bus.data_err_o, 1'b0);
        cyc();
        reset = 1'b1;
        bus.instr_req_i  = 1'b1;
        bus.instr_addr_i = 32'h80;
        bus.data_req_i   = 1'b1;
        bus.data_addr_i  = 32'h100;
        @(negedge clk);
        check("rst_n2_rvalid", bus.data_rvalid_o, 1'b0);
        check("rst_n2_count", err_count_o, 16'h0);
        check("post_rst_data_gnt", bus.data_gnt_o, 1'b1);
        cyc();
        idle();
        cyc();

        // saturate the error counter
        bus.instr_req_i  = 1'b1;
        bus.instr_addr_i = 32'hFFFF_FFF0;
        bus.data_req_i   = 1'b1;
        bus.data_addr_i  = 32'h0004_0000;
        repeat (65540) cyc();
        idle();
        @(negedge clk);
        check("sat_count", err_count_o, 16'hFFFF);
        cyc();
        @(negedge clk);
        check("sat_hold", err_count_o, 16'hFFFF);
        cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
